// File: rtl/product_bcd_converter_if.sv
// Valid/ready bundle between the multiplier product and the
// BCD converter / display path.
interface product_bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    P;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] BCD;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output P, in_valid, out_ready,
    input  in_ready, BCD, out_valid, busy
  );

  modport slave (
    input  P, in_valid, out_ready,
    output in_ready, BCD, out_valid, busy
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter, double dabble,
// one input bit per clock, valid/ready on both sides.
module product_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic               clk,
  input logic               rst_n,
  product_bcd_converter_if.slave bus
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint DecRange = pow10(DIGITS);
  localparam longint BinMax   = (longint'(1) << WIDTH) - 1;
  localparam int     CW       = $clog2(WIDTH + 1);
  localparam int     BW       = 4 * DIGITS;

  if (DecRange <= BinMax) begin : g_bad_digits
    $error("DIGITS too small to hold 2**WIDTH-1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    adj;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    adj     = acc_q;
    // add-3 correction happens before the shift in the same edge
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.P;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CONV;
        end
      end
      CONV: begin
        {acc_d, sr_d} = {adj, sr_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == CONV);
  assign bus.BCD       = acc_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: decimal
// reference model, directed cases, exhaustive and random.
module tb_product_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  typedef struct {
    logic [BW-1:0] bcd;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;
  exp_t exp_q[$];
  int   rise_q[$];
  logic [BW-1:0] held;
  bit   vprev;

  product_bcd_converter_if #(
    .WIDTH(WIDTH),
    .DIGITS(DIGITS)
  ) bus ();

  product_bcd_converter #(
    .WIDTH(WIDTH),
    .DIGITS(DIGITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                  nm, act, req, cyc);
  endtask

  // accept side of the scoreboard
  initial cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) exp_q.delete();
    else if (bus.in_valid && bus.in_ready)
      exp_q.push_back('{ref_bcd(int'(bus.P)), cyc + 1});
    cyc = cyc + 1;
  end

  // output monitor
  always @(negedge clk) begin
    if (rst_n) begin
      chk(!(bus.in_ready && bus.out_valid), "ready_valid_excl",
          {bus.in_ready, bus.out_valid}, 0);
      if (bus.out_valid) begin
        if (!vprev) begin
          exp_t e;
          rise_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk(0, "extra_out_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            held = e.bcd;
            chk(bus.BCD == e.bcd, "bcd_value", bus.BCD, e.bcd);
            chk(cyc - e.cyc == WIDTH, "latency",
                cyc - e.cyc, WIDTH);
          end
        end else begin
          chk(bus.BCD == held, "bcd_hold", bus.BCD, held);
        end
        chk(bus.busy == 1'b0, "busy_in_done", bus.busy, 0);
      end
      vprev = bus.out_valid;
    end else begin
      vprev = 1'b0;
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(bus.in_ready, nm, bus.in_ready, 1);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(bus.out_valid, nm, bus.out_valid, 1);
  endtask

  task automatic convert(input int v);
    wait_ready("conv_ready");
    bus.P = WIDTH'(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid("conv_valid");
    @(negedge clk);
  endtask

  int sweep[7] = '{0, 1, 9, 10, 99, 100, 255};

  initial begin
    int n0;
    int n;
    n_chk = 0;
    n_pass = 0;
    vprev = 1'b0;
    held = '0;
    rst_n = 1'b0;
    bus.P = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
    chk(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
    chk(bus.busy == 1'b0, "rst_busy", bus.busy, 0);
    chk(bus.BCD == '0, "rst_bcd", bus.BCD, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single conversion of the multiplier maximum
    bus.P = 8'd225;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk(bus.in_ready == 1'b0, "t1_ready_drop", bus.in_ready, 0);
    chk(bus.busy == 1'b1, "t1_busy", bus.busy, 1);
    wait_valid("t1_valid");
    chk(bus.BCD == 12'h225, "t1_bcd", bus.BCD, 12'h225);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk(bus.in_ready == 1'b1, "t1_back_idle", bus.in_ready, 1);
    chk(bus.out_valid == 1'b0, "t1_valid_drop", bus.out_valid, 0);
    chk(bus.BCD == 12'h225, "t1_bcd_kept", bus.BCD, 12'h225);

    foreach (sweep[i]) convert(sweep[i]);

    // backpressure with an ignored in_valid
    bus.out_ready = 1'b0;
    convert(144);
    wait_valid("bp_valid");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.P = 8'd7;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      chk(bus.out_valid, "bp_hold_valid", bus.out_valid, 1);
      chk(bus.in_ready == 1'b0, "bp_ready", bus.in_ready, 0);
      chk(bus.BCD == 12'h144, "bp_bcd", bus.BCD, 12'h144);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // reset in the middle of a conversion
    wait_ready("rst_mid_ready");
    bus.P = 8'd200;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk(bus.out_valid == 1'b0, "rm_valid", bus.out_valid, 0);
    chk(bus.busy == 1'b0, "rm_busy", bus.busy, 0);
    chk(bus.BCD == '0, "rm_bcd", bus.BCD, 0);
    chk(bus.in_ready == 1'b1, "rm_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    n0 = rise_q.size();
    repeat (15) @(negedge clk);
    chk(rise_q.size() == n0, "rm_no_valid", rise_q.size(), n0);

    // back-to-back
    bus.out_ready = 1'b1;
    wait_ready("b2b_ready");
    n0 = rise_q.size();
    bus.P = 8'd36;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.P = 8'd49;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (rise_q.size() < n0 + 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rise_q.size() >= n0 + 2)
      chk(rise_q[n0+1] - rise_q[n0] == WIDTH + 2, "b2b_spacing",
          rise_q[n0+1] - rise_q[n0], WIDTH + 2);
    else
      chk(0, "b2b_results", rise_q.size() - n0, 2);

    // exhaustive
    for (int v = 0; v < (1 << WIDTH); v++) convert(v);

    // random traffic with random stalls
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = 1'($urandom);
      bus.P = WIDTH'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (25) @(negedge clk);

    chk(exp_q.size() == 0, "missing_out_valid", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Sequential binary-to-BCD converter, directly downstream of the 4x4 combinational multiplier.
- Accepts the 8-bit product P and converts it to packed decimal digits using shift-and-add-3 (double dabble), one bit per clock.
- Presents the result with a valid/ready handshake to the display / 7-segment driver stage.

Parameters:
- WIDTH, 8, binary input width (product width).
- DIGITS, 3, number of BCD output digits.
  - Must satisfy 10^DIGITS > 2^WIDTH - 1.
  - Elaboration fails (generate-time error) otherwise.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- P  input  WIDTH  binary product to convert; sampled only on the accept edge.
- in_valid  input  1  upstream asserts when P is valid.
- in_ready  output  1  block can accept a new P.
- BCD  output  4*DIGITS  packed BCD result; digit k = BCD[4k+3:4k], digit 0 = units.
- out_valid  output  1  BCD holds a completed conversion.
- out_ready  input  1  downstream consumes BCD.
- busy  output  1  conversion in progress.

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is synchronous and active-low.
- Reset values (rst_n low at an edge):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0, BCD = 0.
  - Internal shift register and bit counter = 0.
- State machine: IDLE, CONV, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture P into the binary shift register, clear the BCD accumulator, load counter = WIDTH, go to CONV.
  - Otherwise stay in IDLE.
- CONV:
  - in_ready = 0, busy = 1.
  - Each edge, applied as one combined step:
    - Every accumulator digit >= 5 gets +3 (4-bit add, no carry out of the digit).
    - Then {accumulator, shift register} shifts left by 1; the MSB of P enters digit 0 bit 0.
    - Counter decrements by 1.
  - When the counter reaches 1 at an edge, that edge performs the final shift and transitions to DONE.
- DONE:
  - out_valid = 1, busy = 0, in_ready = 0.
  - BCD is held stable while out_valid = 1 and out_ready = 0; unbounded backpressure is allowed.
  - On an edge with out_ready = 1: go to IDLE. out_valid drops, BCD keeps its last value.
- Latency:
  - out_valid rises exactly WIDTH edges after the accept edge (8 cycles at default).
  - Minimum accept-to-accept spacing is WIDTH + 2 cycles.
  - in_ready and out_valid are never both high.
- P is ignored outside the IDLE accept edge. Changes on P during CONV/DONE have no effect.
- in_valid high while in_ready = 0 is ignored; upstream must hold it (standard valid/ready).
- P = 0 converts normally (WIDTH cycles) and yields BCD = 0.
- Maximum input 2^WIDTH - 1 must convert exactly: 255 -> digits 2,5,5. The multiplier maximum 225 -> 2,2,5.
- Reset mid-CONV or mid-DONE: the next edge with rst_n low forces all reset values. The partial result is discarded; no out_valid pulse.
- Reset has priority over every handshake in the same cycle.

Test Plan:
- Reset, then P = 8'd225 with in_valid for 1 cycle:
  - in_ready drops the next cycle.
  - out_valid rises 8 edges after accept with BCD = 12'h225, busy low.
  - out_ready = 1 returns to IDLE with in_ready = 1.
- Sweep P = 0, 1, 9, 10, 99, 100, 255 (out_ready tied high):
  - BCD = 12'h000, 001, 009, 010, 099, 100, 255 respectively.
  - Each completes in 8 cycles.
- Backpressure:
  - Convert P = 8'd144 with out_ready = 0 for 20 cycles; out_valid stays 1 and BCD stays 12'h144 throughout, in_ready stays 0.
  - A new in_valid with P = 8'd7 during this window is not accepted.
- Reset mid-conversion:
  - Accept P = 8'd200, pull rst_n low at cycle 4 of CONV.
  - Next cycle: out_valid = 0, busy = 0, BCD = 0, in_ready = 1.
  - No out_valid appears afterwards until a new accept.
- Back-to-back:
  - in_valid held high with P = 8'd36, then 8'd49 presented once in_ready reasserts, out_ready high.
  - Two results, 12'h036 then 12'h049, spaced exactly 10 cycles apart.
- Exhaustive: all 256 values of P checked against the decimal reference; no mismatch, no extra or missing out_valid pulses.
